// File: rtl/main_memory_model.sv
// Block-granular backing store on the memory side of the L2: one block read or write
// at a time, answered with a one-cycle ready/hit strobe after a fixed latency.
module main_memory_model #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 16,
  parameter int LATENCY    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr_i,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_wdata_i,
  input  logic                                  mem_read_i,
  input  logic                                  mem_write_i,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_rdata_o,
  output logic                                  mem_ready_o,
  output logic                                  mem_hit_o,
  output logic                                  mem_busy_o
);

  localparam int OFF = $clog2(BLOCK_SIZE) + 2;
  localparam int IDX = $clog2(NUM_BLOCKS);

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e         state_q;
  logic [7:0]     cnt_q;
  logic           wr_q;
  logic           inr_q;
  logic [IDX-1:0] idx_q;
  block_t         wdata_q;
  block_t         rdata_q;
  logic           ready_q, hit_q, busy_q;
  block_t         mem_q [NUM_BLOCKS];

  logic [IDX-1:0] idx_d;
  logic           inr_d;
  logic           unused_offset;

  // Range check and index are resolved at accept so only they need latching.
  assign idx_d         = mem_addr_i[OFF+IDX-1:OFF];
  assign inr_d         = (mem_addr_i[ADDR_WIDTH-1:OFF+IDX] == '0);
  assign unused_offset = ^mem_addr_i[OFF-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      inr_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int b = 0; b < NUM_BLOCKS; b++)
        for (int w = 0; w < BLOCK_SIZE; w++)
          mem_q[b][w] <= DATA_WIDTH'(b * BLOCK_SIZE + w);
    end else begin
      case (state_q)
        IDLE: if (mem_read_i || mem_write_i) begin
          state_q <= BUSY;
          cnt_q   <= 8'(LATENCY - 1);
          wr_q    <= mem_write_i;   // write wins over a simultaneous read
          idx_q   <= idx_d;
          inr_q   <= inr_d;
          wdata_q <= mem_wdata_i;
          busy_q  <= 1'b1;
        end
        BUSY: begin
          if (cnt_q == 8'd0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            hit_q   <= inr_q;
            if (!inr_q)   rdata_q       <= '0;
            else if (wr_q) mem_q[idx_q] <= wdata_q;
            else          rdata_q       <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          hit_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rdata_o = rdata_q;
  assign mem_ready_o = ready_q;
  assign mem_hit_o   = hit_q;
  assign mem_busy_o  = busy_q;

endmodule
